// File: rtl/booth_pkg.sv
// Shared definitions for the sequential radix-2 Booth multiplier:
// FSM state encoding, Booth operation encoding and the Booth recoding helper.
package booth_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    BOOTH_NOP = 2'd0,
    BOOTH_ADD = 2'd1,
    BOOTH_SUB = 2'd2
  } booth_op_e;

  // Radix-2 Booth recoding of {Q[0], q-1}: 01 adds M, 10 subtracts M.
  function automatic booth_op_e booth_decode(input logic [1:0] qb);
    booth_op_e op;
    case (qb)
      2'b01:   op = BOOTH_ADD;
      2'b10:   op = BOOTH_SUB;
      default: op = BOOTH_NOP;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/booth_step_w.sv
// One combinational radix-2 Booth step on W-bit words:
// conditional add/sub of M into A, then arithmetic shift right of {A, Q, q-1}.
// qq_i / qq_o carry {Q, q-1}; bit 0 is the Booth history bit.
module booth_step_w
  import booth_pkg::*;
#(
  parameter int W = 5
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] m_i,
  input  logic [W-1:0] qq_i,
  output logic [W-1:0] a_o,
  output logic [W-1:0] qq_o
);

  logic [W-1:0] sum;
  booth_op_e    op;

  // Add/subtract M (wrapping mod 2^W) and shift the concatenation right by one.
  always_comb begin
    op  = booth_decode(qq_i[1:0]);
    sum = a_i;
    case (op)
      BOOTH_ADD: sum = a_i + m_i;
      BOOTH_SUB: sum = a_i - m_i;
      default:   sum = a_i;
    endcase
    a_o  = {sum[W-1], sum[W-1:1]};
    qq_o = {sum[0], qq_i[W-1:1]};
  end

endmodule

// File: rtl/booth_seq_mult.sv
// Sequential radix-2 Booth multiplier controller.
// Accepts signed operands on start in IDLE, runs WIDTH Booth steps (one per clock)
// and presents the 2*WIDTH-bit signed product with a one-cycle done pulse.
// Optional feature macro: BOOTH_ZERO_SKIP_EN -- a zero operand skips the
// iteration and goes straight to DONE with product 0.
module booth_seq_mult
  import booth_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam int AW    = WIDTH + 1;

  // Handshake: start is a level request sampled only while IDLE; once accepted,
  // busy is high for exactly WIDTH cycles, then done pulses for one cycle with
  // product valid from that cycle until the next accepted start.

  state_e              state_q;
  logic [AW-1:0]       a_q;
  logic [AW-1:0]       qq_q;      // {Q, q-1}
  logic [AW-1:0]       m_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                busy_q;
  logic                done_q;
  logic [2*WIDTH-1:0]  product_q;

  logic [AW-1:0]       a_d;
  logic [AW-1:0]       qq_d;
  logic                last_step;

  booth_step_w #(.W(AW)) u_step (
    .a_i  (a_q),
    .m_i  (m_q),
    .qq_i (qq_q),
    .a_o  (a_d),
    .qq_o (qq_d)
  );

  // Final step is the one taken while the counter holds WIDTH-1.
  always_comb begin
    last_step = (cnt_q == CNT_W'(WIDTH - 1));
  end

  // Control FSM with registered busy/done/product and the iteration datapath.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      a_q       <= '0;
      qq_q      <= '0;
      m_q       <= '0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      product_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
`ifdef BOOTH_ZERO_SKIP_EN
            if ((multiplicand == '0) || (multiplier == '0)) begin
              state_q   <= ST_DONE;
              done_q    <= 1'b1;
              product_q <= '0;
            end else begin
              a_q     <= '0;
              qq_q    <= {multiplier, 1'b0};
              m_q     <= {multiplicand[WIDTH-1], multiplicand};
              cnt_q   <= '0;
              busy_q  <= 1'b1;
              state_q <= ST_RUN;
            end
`else
            a_q     <= '0;
            qq_q    <= {multiplier, 1'b0};
            m_q     <= {multiplicand[WIDTH-1], multiplicand};
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= ST_RUN;
`endif
          end
        end
        ST_RUN: begin
          a_q   <= a_d;
          qq_q  <= qq_d;
          cnt_q <= cnt_q + CNT_W'(1);
          if (last_step) begin
            // Capture the product as DONE is entered so it is valid with done.
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
            product_q <= {a_d[WIDTH-1:0], qq_d[WIDTH:1]};
            state_q   <= ST_DONE;
          end
        end
        ST_DONE: begin
          done_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign product = product_q;

endmodule

// File: tb/tb_booth_seq_mult.sv
// Self-checking bench for booth_seq_mult (WIDTH=4).
// Honours BOOTH_ZERO_SKIP_EN for zero-operand latency expectations.
module tb_booth_seq_mult;

  localparam int WIDTH = 4;
  localparam int PW    = 2 * WIDTH;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [WIDTH-1:0]  mcand;
  logic [WIDTH-1:0]  mplier;
  logic              busy;
  logic              done;
  logic [PW-1:0]     product;

  int checks = 0;
  int errors = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  booth_seq_mult #(.WIDTH(WIDTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .multiplicand (mcand),
    .multiplier   (mplier),
    .busy         (busy),
    .done         (done),
    .product      (product)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Signed product by plain arithmetic, truncated to 2*WIDTH bits.
  function automatic logic [PW-1:0] ref_mul(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    int p;
    p = int'($signed(a)) * int'($signed(b));
    return p[PW-1:0];
  endfunction

  // m_ph: cycles since acceptance (0 = idle, 1..WIDTH busy, WIDTH+1 done).
  int             m_ph   = 0;
  logic [PW-1:0]  m_prod = '0;
  logic [PW-1:0]  m_pend = '0;
  logic [PW-1:0]  exp_q[$];
  bit             chk_en = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_ph   = 0;
      m_prod = '0;
      exp_q.delete();
    end else if (m_ph == 0) begin
      if (start) begin
        m_pend = ref_mul(mcand, mplier);
        exp_q.push_back(m_pend);
`ifdef BOOTH_ZERO_SKIP_EN
        if (mcand == '0 || mplier == '0) begin
          m_ph   = WIDTH + 1;
          m_prod = '0;
        end else begin
          m_ph = 1;
        end
`else
        m_ph = 1;
`endif
      end
    end else if (m_ph == WIDTH + 1) begin
      m_ph = 0;
    end else begin
      m_ph++;
      if (m_ph == WIDTH + 1) m_prod = m_pend;
    end
  end

  // ---------------- compare process / scoreboard ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      check("busy", 32'(busy), 32'(m_ph >= 1 && m_ph <= WIDTH));
      check("done", 32'(done), 32'(m_ph == WIDTH + 1));
      check("product", 32'(product), 32'(m_prod));
      if (done) begin
        if (exp_q.size() == 0) check("sb_unexpected_done", 32'(1), 32'(0));
        else check("sb_product", 32'(product), 32'(exp_q.pop_front()));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic [PW-1:0] exp_lit, input string name);
    int n;
    int lat;
    lat = WIDTH + 1;
`ifdef BOOTH_ZERO_SKIP_EN
    if (a == '0 || b == '0) lat = 1;
`endif
    @(negedge clk);
    mcand  = a;
    mplier = b;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 1;
    while (!done && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({name, "_latency"}, 32'(n), 32'(lat));
    check({name, "_product"}, 32'(product), 32'(exp_lit));
  endtask

  task automatic count_dones(input int cycles, output int cnt);
    cnt = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (done) cnt++;
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int nd;
    rst    = 1'b1;
    start  = 1'b0;
    mcand  = '0;
    mplier = '0;
    repeat (2) @(negedge clk);
    check("reset_busy", 32'(busy), 32'(0));
    check("reset_done", 32'(done), 32'(0));
    check("reset_product", 32'(product), 32'(0));
    rst    = 1'b0;
    chk_en = 1'b1;

    // Hand-computed values that pin the model.
    check("model_3x2", 32'(ref_mul(4'h3, 4'h2)), 32'h06);
    check("model_m8xm8", 32'(ref_mul(4'h8, 4'h8)), 32'h40);

    // Directed vectors.
    run_op(4'h3, 4'h2, 8'h06, "3x2");
    run_op(4'hD, 4'h5, 8'hF1, "m3x5");
    run_op(4'h8, 4'h8, 8'h40, "m8xm8");
    run_op(4'h7, 4'h8, 8'hC8, "7xm8");
    run_op(4'h8, 4'h7, 8'hC8, "m8x7");
    run_op(4'h0, 4'h5, 8'h00, "0x5");
    run_op(4'hF, 4'hF, 8'h01, "m1xm1");

    // start pulsed in RUN and in DONE with new operands must be ignored.
    @(negedge clk);
    mcand = 4'h3; mplier = 4'h2; start = 1'b1;
    @(negedge clk);                       // first RUN cycle
    start = 1'b0;
    @(negedge clk);                       // second RUN cycle
    mcand = 4'h7; mplier = 4'h7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);            // DONE cycle
    check("ign_done", 32'(done), 32'(1));
    check("ign_product", 32'(product), 32'h06);
    mcand = 4'hF; mplier = 4'h3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    count_dones(10, nd);
    check("ign_no_extra_done", 32'(nd), 32'(0));

    // Reset during the second RUN cycle discards the operation.
    @(negedge clk);
    mcand = 4'h3; mplier = 4'h2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_done", 32'(done), 32'(0));
    check("rst_product", 32'(product), 32'(0));
    count_dones(10, nd);
    check("rst_no_done", 32'(nd), 32'(0));
    run_op(4'hD, 4'h5, 8'hF1, "after_rst");

    // Exhaustive sweep, back-to-back starts.
    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < 16; j++) begin
        run_op(4'(i), 4'(j), ref_mul(4'(i), 4'(j)), "exh");
      end
    end

    repeat (3) @(negedge clk);
    check("sb_drained", 32'(exp_q.size()), 32'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global time bound.
  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
